branch_hazard_ctrl: RTL and testbench
=====================================

# branch_hazard_ctrl

Decode-stage hazard scheduler for the comparator that resolves branches in D and for the other D-stage operand consumers. It keeps a shadow pipeline of destination register and Tnew for the E, M and W stages. From that state it drives a stall that freezes PC and IF/ID and injects a bubble into ID/EX. It also drives the forwarding selects that feed the comparator's A and B operands. Sits beside the ID stage; the main controller decodes Tuse/Tnew for it.

## Interface
Parameters:
- `REG_AW`, 5, register-address width.
- `CNT_W`, 32, stall-statistics counter width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `d_valid`  in  1  D stage holds a real instruction.
- `d_rs`, `d_rt`  in  REG_AW  source registers of the D instruction.
- `d_tuse_rs`, `d_tuse_rt`  in  2  cycles until each operand is consumed: 0 = branch comparator, 1 = E ALU, 2 = M store data, 3 = unused.
- `d_wr`  in  REG_AW  destination register; 0 = none.
- `d_tnew`  in  2  cycles after entering E until the result is forwardable: 0 = jal/lui, 1 = ALU, 2 = load.
- `stall`  out  1  freeze PC/IF-ID and bubble ID/EX.
- `fwd_a_sel`, `fwd_b_sel`  out  2  D-stage operand source: 0 = RF, 1 = E, 2 = M, 3 = W.
- `stall_cnt`  out  CNT_W  number of stall cycles since reset, saturating.

## Operation
- Shadow entries: E{wr,tnew}, M{wr,tnew}, W{wr}.
- Each clock, all shadow stages update together:
  - E loads D's {d_wr, d_tnew} when `d_valid` and not `stall`. Otherwise E loads a bubble {0,0}.
  - M loads E with tnew decremented, saturating at 0.
  - W loads M.wr.
- Per-operand check (operand r, use t), evaluated only when `d_valid`, r≠0 and t≠3:
  - Hazard if (E.wr==r and E.tnew>t) or (M.wr==r and M.tnew>t).
  - Forward source, first match wins: E.wr==r and E.tnew==0 → E; else M.wr==r and M.tnew==0 → M; else W.wr==r → W; else RF.
  - The nearest matching stage shadows older stages. Example: E.wr==r with E.tnew>0 but no hazard (t large enough) selects RF now; the E-stage forwarding unit handles that operand later.
- `stall` = hazard(rs) OR hazard(rt).
- Forward selects are meaningful only when `stall`=0. During a stall they still show the computed source and downstream ignores them.
- Register 0 never hazards and never forwards.
- `stall_cnt` increments in every cycle with `stall`=1 and holds at all-ones.

## Timing
- `stall` and `fwd_*_sel` are combinational from registered shadow state plus D inputs, within the same cycle. There is no output latency.
- Shadow state has one-cycle update latency.
- Reset: all shadow wr/tnew = 0 and `stall_cnt` = 0. Consequently `stall`=0 and `fwd_*_sel`=0 with any D inputs.
- Reset mid-stall: the next cycle has an empty shadow, so the stall drops immediately.
- Stall lifetime:
  - A load followed directly by a beq on its result stalls 2 cycles.
  - An ALU op followed directly by a beq on its result stalls 1 cycle.
  - A load followed by an ALU consumer stalls 1 cycle.
- Both operands on the same register are handled independently; the result is identical.
- `d_valid`=0 means no stall and a bubble enters E.

## Structure
- Shared macro header (`macro.v`):
  - TUSE/TNEW encodings.
  - `FWD_RF/FWD_E/FWD_M/FWD_W` codes.
  - Register-zero constant.
- One sub-module, `hz_operand`: hazard flag plus forward select for a single operand. Instantiated twice (rs, rt).
- Top level holds the shadow registers and the counter.

## Test plan
- Reset: assert `reset` with D = beq $1,$2 and the shadow preloaded → `stall`=0, selects 0, `stall_cnt`=0 the next cycle.
- Load-use branch: lw $3 (tnew 2), then beq $3,$0 (tuse 0) → `stall`=1 for 2 cycles, then `fwd_a_sel`=W(3), `stall_cnt`=2.
- ALU-branch: addu $4 (tnew 1), then beq $4,$4 → 1 stall cycle, then both selects = M(2).
- jal forwarding: jal writing $31 (tnew 0), then beq $31,$5 → no stall, `fwd_a_sel`=E(1), `fwd_b_sel`=RF(0).
- Priority/zero: $6 in both E (tnew 0) and W → select E. Dest $0 with d_rs=0 → never stall, select RF.
- Saturation: force `stall_cnt` near all-ones with CNT_W=4, then hold a stall for 20 cycles → reads 15.

Source files
------------

// File: rtl/branch_hazard_ctrl_pkg.sv
// rtl/branch_hazard_ctrl_pkg.sv - shared encodings for the D-stage hazard scheduler
package branch_hazard_ctrl_pkg;

  // Tuse code for an operand the instruction does not read.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_hz_operand.sv
// rtl/branch_hazard_ctrl_hz_operand.sv - hazard flag and forward select for one D-stage operand
module branch_hazard_ctrl_hz_operand
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              valid,
  input  logic [REG_AW-1:0] r,
  input  logic [1:0]        tuse,
  input  logic [REG_AW-1:0] e_wr,
  input  logic [1:0]        e_tnew,
  input  logic [REG_AW-1:0] m_wr,
  input  logic [1:0]        m_tnew,
  input  logic [REG_AW-1:0] w_wr,
  output logic              hazard,
  output fwd_sel_e          sel
);

  logic active;
  logic e_hit;
  logic m_hit;
  logic w_hit;

  assign active = valid && (r != '0) && (tuse != TUSE_NONE);
  assign e_hit  = active && (e_wr == r);
  assign m_hit  = active && (m_wr == r);
  assign w_hit  = active && (w_wr == r);

  // The youngest stage writing r owns it: if its value is not ready yet,
  // older copies are stale and the operand is picked up again downstream.
  always_comb begin
    hazard = (e_hit && (e_tnew > tuse)) || (m_hit && (m_tnew > tuse));
    sel    = FWD_RF;
    if (e_hit) begin
      if (e_tnew == 2'd0) sel = FWD_E;
    end else if (m_hit) begin
      if (m_tnew == 2'd0) sel = FWD_M;
    end else if (w_hit) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - E/M/W shadow pipeline, stall generation and stall statistics
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [1:0]        d_tuse_rs,
  input  logic [1:0]        d_tuse_rt,
  input  logic [REG_AW-1:0] d_wr,
  input  logic [1:0]        d_tnew,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [REG_AW-1:0] e_wr;
  logic [REG_AW-1:0] m_wr;
  logic [REG_AW-1:0] w_wr;
  logic [1:0]        e_tnew;
  logic [1:0]        m_tnew;
  logic              hz_rs;
  logic              hz_rt;
  fwd_sel_e          sel_rs;
  fwd_sel_e          sel_rt;

  branch_hazard_ctrl_hz_operand #(.REG_AW(REG_AW)) u_hz_rs (
    .valid (d_valid), .r (d_rs), .tuse (d_tuse_rs),
    .e_wr (e_wr), .e_tnew (e_tnew), .m_wr (m_wr), .m_tnew (m_tnew), .w_wr (w_wr),
    .hazard (hz_rs), .sel (sel_rs)
  );

  branch_hazard_ctrl_hz_operand #(.REG_AW(REG_AW)) u_hz_rt (
    .valid (d_valid), .r (d_rt), .tuse (d_tuse_rt),
    .e_wr (e_wr), .e_tnew (e_tnew), .m_wr (m_wr), .m_tnew (m_tnew), .w_wr (w_wr),
    .hazard (hz_rt), .sel (sel_rt)
  );

  assign stall     = hz_rs || hz_rt;
  assign fwd_a_sel = sel_rs;
  assign fwd_b_sel = sel_rt;

  // A stalled or invalid D slot sends a bubble into E.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_wr   <= '0;
      e_tnew <= '0;
      m_wr   <= '0;
      m_tnew <= '0;
      w_wr   <= '0;
    end else begin
      if (d_valid && !stall) begin
        e_wr   <= d_wr;
        e_tnew <= d_tnew;
      end else begin
        e_wr   <= '0;
        e_tnew <= '0;
      end
      m_wr   <= e_wr;
      m_tnew <= tnew_dec(e_tnew);
      w_wr   <= m_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - directed vector bench for branch_hazard_ctrl
module tb_branch_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs, d_rt, d_wr;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        stall, stall4;
  logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_a4, fwd_b4;
  logic [31:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl dut (
    .clk (clk), .reset (reset), .d_valid (d_valid),
    .d_rs (d_rs), .d_rt (d_rt), .d_tuse_rs (d_tuse_rs), .d_tuse_rt (d_tuse_rt),
    .d_wr (d_wr), .d_tnew (d_tnew),
    .stall (stall), .fwd_a_sel (fwd_a_sel), .fwd_b_sel (fwd_b_sel), .stall_cnt (stall_cnt)
  );

  branch_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut4 (
    .clk (clk), .reset (reset), .d_valid (d_valid),
    .d_rs (d_rs), .d_rt (d_rt), .d_tuse_rs (d_tuse_rs), .d_tuse_rt (d_tuse_rt),
    .d_wr (d_wr), .d_tnew (d_tnew),
    .stall (stall4), .fwd_a_sel (fwd_a4), .fwd_b_sel (fwd_b4), .stall_cnt (stall_cnt4)
  );

  // Expected fields set to -1 are not compared in that cycle.
  typedef struct {
    bit rst;
    bit v;
    int rs, rt, ur, ut, wr, tn;
    int es, ea, eb, ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit v, int rs, int rt, int ur, int ut, int wr, int tn,
                              int es, int ea, int eb, int ec);
    vec_t x;
    x.rst = rst; x.v = v; x.rs = rs; x.rt = rt; x.ur = ur; x.ut = ut; x.wr = wr; x.tn = tn;
    x.es = es; x.ea = ea; x.eb = eb; x.ec = ec;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit v, input int rs, input int rt, input int ur,
                       input int ut, input int wr, input int tn);
    reset = rst; d_valid = v;
    d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = 2'(ur); d_tuse_rt = 2'(ut);
    d_wr = 5'(wr); d_tnew = 2'(tn);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset, valid, rs, rt, tuse_rs, tuse_rt, wr, tnew, exp stall, sel_a, sel_b, cnt
    tbl.push_back(mk(0, 1, 0, 0, 3, 3,  1, 2,  0, 0, 0,  0)); // lw $1 preloads shadow
    tbl.push_back(mk(1, 1, 1, 2, 0, 0,  0, 0, -1,-1,-1,  0)); // reset with beq $1,$2
    tbl.push_back(mk(0, 1, 1, 2, 0, 0,  0, 0,  0, 0, 0,  0)); // shadow empty after reset
    tbl.push_back(mk(0, 1, 0, 0, 3, 3,  3, 2,  0, 0, 0,  0)); // lw $3
    tbl.push_back(mk(0, 1, 3, 0, 0, 0,  0, 0,  1, 0, 0,  0)); // beq $3,$0 stall 1
    tbl.push_back(mk(0, 1, 3, 0, 0, 0,  0, 0,  1, 0, 0,  1)); // stall 2
    tbl.push_back(mk(0, 1, 3, 0, 0, 0,  0, 0,  0, 3, 0,  2)); // forward from W
    tbl.push_back(mk(0, 1, 0, 0, 3, 3,  4, 1,  0, 0, 0,  2)); // addu $4
    tbl.push_back(mk(0, 1, 4, 4, 0, 0,  0, 0,  1, 0, 0,  2)); // beq $4,$4 stall
    tbl.push_back(mk(0, 1, 4, 4, 0, 0,  0, 0,  0, 2, 2,  3)); // both from M
    tbl.push_back(mk(0, 1, 0, 0, 3, 3, 31, 0,  0, 0, 0,  3)); // jal -> $31
    tbl.push_back(mk(0, 1,31, 5, 0, 0,  0, 0,  0, 1, 0,  3)); // beq $31,$5
    tbl.push_back(mk(0, 1, 0, 0, 3, 3,  6, 1,  0, 0, 0,  3)); // addu $6
    tbl.push_back(mk(0, 1, 0, 0, 3, 3,  0, 0,  0, 0, 0,  3)); // nop
    tbl.push_back(mk(0, 1, 0, 0, 3, 3,  6, 0,  0, 0, 0,  3)); // lui $6 (E) while old $6 heads to W
    tbl.push_back(mk(0, 1, 6, 6, 0, 0,  0, 0,  0, 1, 1,  3)); // E wins over W
    tbl.push_back(mk(0, 1, 0, 0, 3, 3,  0, 2,  0, 0, 0,  3)); // load into $0
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0,  0, 0, 0,  3)); // beq $0,$0 never stalls
    tbl.push_back(mk(0, 1, 0, 0, 3, 3,  7, 2,  0, 0, 0,  3)); // lw $7
    tbl.push_back(mk(0, 1, 0, 7, 3, 1,  8, 1,  1, 0, 0,  3)); // ALU uses $7 on rt: stall
    tbl.push_back(mk(0, 1, 0, 7, 3, 1,  8, 1,  0, 0, 0,  4)); // M not ready yet -> RF
    tbl.push_back(mk(0, 0, 8, 0, 0, 3,  0, 0,  0, 0, 0,  4)); // d_valid=0: no stall
    tbl.push_back(mk(0, 1, 0, 0, 3, 3,  9, 2,  0, 0, 0,  4)); // lw $9
    tbl.push_back(mk(1, 1, 9, 0, 0, 3,  0, 0, -1,-1,-1,  4)); // reset mid-stall
    tbl.push_back(mk(0, 1, 9, 0, 0, 3,  0, 0,  0, 0, 0,  0)); // stall gone

    drive(1, 0, 0, 0, 3, 3, 0, 0);
    tick();
    tick();
    @(negedge clk);
    chk("reset_stall", -1, stall, 0);
    chk("reset_cnt", -1, stall_cnt, 0);
    chk("reset_cnt4", -1, stall_cnt4, 0);
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].ur, tbl[i].ut, tbl[i].wr, tbl[i].tn);
      @(negedge clk);
      if (tbl[i].es >= 0) chk("stall", i, stall, tbl[i].es);
      if (tbl[i].ea >= 0) chk("fwd_a_sel", i, fwd_a_sel, tbl[i].ea);
      if (tbl[i].eb >= 0) chk("fwd_b_sel", i, fwd_b_sel, tbl[i].eb);
      if (tbl[i].ec >= 0) chk("stall_cnt", i, stall_cnt, tbl[i].ec);
      tick();
    end

    // Counter saturation: each lw/beq pair costs two stall cycles.
    drive(1, 0, 0, 0, 3, 3, 0, 0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 0, 0, 3, 3, 3, 2);
      tick();
      drive(0, 1, 3, 0, 0, 3, 0, 0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("sat_stall", k * 3 + c, stall, (c < 2) ? 1 : 0);
        tick();
      end
      if (k == 6) begin
        @(negedge clk);
        chk("sat_cnt4_mid", k, stall_cnt4, 14);
      end
    end
    drive(0, 0, 0, 0, 3, 3, 0, 0);
    @(negedge clk);
    chk("sat_cnt4", 0, stall_cnt4, 15);
    chk("sat_cnt32", 0, stall_cnt, 20);
    tick();
    @(negedge clk);
    chk("sat_cnt4_hold", 1, stall_cnt4, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
